// File: rtl/fetch_seq_if.sv
// Bus between the program loader / execution unit and the fetch sequencer.
// An instruction is consumed on a rising edge where inst_valid=1 and stall=0; while stall=1 inst_reg/pc hold.
interface fetch_seq_if;
  logic       prog_we;
  logic [5:0] prog_addr;
  logic [7:0] prog_data;
  logic       run;
  logic       stall;
  logic       skip;
  logic [7:0] inst_reg;
  logic       inst_valid;
  logic [5:0] pc;
  logic       halted;
  logic [1:0] state;

  modport master (
    output prog_we, prog_addr, prog_data, run, stall, skip,
    input  inst_reg, inst_valid, pc, halted, state
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, run, stall, skip,
    output inst_reg, inst_valid, pc, halted, state
  );
endinterface

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: 64x8 program memory, IDLE/FETCH/EXEC/HALT FSM,
// skip, GOTO (2'b11 prefix) and HALT (8'hFF) handling; state exported for debug.
module fetch_seq (
  input  logic       clk,
  input  logic       reset,
  fetch_seq_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  logic [1:0] state_q;
  logic [5:0] pc_q;
  logic [7:0] inst_q;
  logic [7:0] mem [0:63];

  logic       is_halt;
  logic       is_goto;
  logic       mem_wr_en;
  logic [5:0] pc_step;

  assign is_halt   = (inst_q == 8'hFF);
  assign is_goto   = (inst_q[7:6] == 2'b11) && !is_halt;
  assign mem_wr_en = bus.prog_we && ((state_q == IDLE) || (state_q == HALT));
  // 6-bit add wraps naturally, giving modulo-64 pc arithmetic.
  assign pc_step   = pc_q + (bus.skip ? 6'd2 : 6'd1);

  // Program memory has no reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (mem_wr_en) begin
      mem[bus.prog_addr] <= bus.prog_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= 6'd0;
      inst_q  <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.run) begin
            pc_q    <= 6'd0;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          inst_q  <= mem[pc_q];
          state_q <= EXEC;
        end
        EXEC: begin
          if (is_halt) begin
            state_q <= HALT;
          end else if (is_goto) begin
            pc_q    <= inst_q[5:0];
            state_q <= FETCH;
          end else if (!bus.stall) begin
            pc_q    <= pc_step;
            state_q <= FETCH;
          end
        end
        HALT: begin
          if (bus.run) begin
            pc_q    <= 6'd0;
            state_q <= FETCH;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.inst_reg   = inst_q;
  assign bus.inst_valid = (state_q == EXEC) && !is_halt && !is_goto;
  assign bus.pc         = pc_q;
  assign bus.halted     = (state_q == HALT);
  assign bus.state      = state_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Scoreboard bench for fetch_seq: an instruction-level program interpreter predicts
// the delivered (pc, instruction) stream; a negedge monitor checks every valid cycle.
module tb_fetch_seq;

  logic clk;
  logic reset;
  fetch_seq_if bus ();

  fetch_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [13:0] exp_q[$];     // {pc, inst}
  logic [7:0]  m [64];       // reference copy of program memory
  int          stall_v [32];
  bit          skip_v  [32];
  bit          force_poke1 = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: plain instruction semantics
  function automatic bit is_goto_w(input logic [7:0] w);
    return (w[7:6] == 2'b11) && (w != 8'hFF);
  endfunction

  function automatic int follow(input int p);
    int q = p;
    for (int h = 0; h < 64; h++) begin
      if (is_goto_w(m[q])) q = int'(m[q][5:0]);
      else break;
    end
    return q;
  endfunction

  task automatic gen_program();
    int t;
    int tries;
    for (int i = 0; i < 64; i++) begin
      int r = $urandom_range(0, 15);
      if (r == 0)      m[i] = 8'hFF;
      else if (r <= 2) m[i] = 8'hC0;
      else             m[i] = 8'($urandom_range(0, 191));
    end
    for (int i = 0; i < 64; i++) begin
      if (is_goto_w(m[i])) begin
        tries = 0;
        t = $urandom_range(0, 63);
        while (is_goto_w(m[t]) && tries < 200) begin
          t = $urandom_range(0, 63);
          tries++;
        end
        m[i] = is_goto_w(m[t]) ? 8'h00 : (8'hC0 | 8'(t));
      end
    end
  endtask

  // driver tasks
  task automatic write_word(input int a, input logic [7:0] d);
    bus.prog_we   = 1'b1;
    bus.prog_addr = 6'(a);
    bus.prog_data = d;
    m[a] = d;
    @(posedge clk); #1;
    bus.prog_we = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < 64; i++) write_word(i, m[i]);
  endtask

  task automatic clear_ctl();
    for (int i = 0; i < 32; i++) begin
      stall_v[i] = 0;
      skip_v[i]  = 1'b0;
    end
  endtask

  // Random run/prog_we activity while running; none of it may change anything.
  task automatic poke();
    bus.run       = 1'($urandom_range(0, 1));
    bus.prog_we   = force_poke1 ? 1'b1 : 1'($urandom_range(0, 1));
    bus.prog_addr = force_poke1 ? 6'd1 : 6'($urandom_range(0, 63));
    bus.prog_data = 8'($urandom);
  endtask

  task automatic start_run(input bit lat);
    bus.run = 1'b1;
    @(posedge clk); #1;
    bus.run = 1'b0;
    chk("fetch_pc", 32'(bus.pc), 32'd0);
    chk("fetch_no_valid", 32'(bus.inst_valid), 32'd0);
    chk("run_clears_halted", 32'(bus.halted), 32'd0);
    @(posedge clk); #1;
    if (lat) chk("first_latency", 32'(bus.inst_valid), 32'd1);
  endtask

  task automatic deliver(input int ns, input bit sk, output bit ok);
    int g = 0;
    ok = 1'b1;
    while (!bus.inst_valid) begin
      @(posedge clk); #1;
      g++;
      if (g > 8) begin
        checks++;
        errors++;
        $display("FAIL valid_timeout: got no inst_valid within 8 cycles at %0t", $time);
        ok = 1'b0;
        return;
      end
    end
    for (int i = 0; i < ns; i++) begin
      bus.stall = 1'b1;
      bus.skip  = 1'($urandom_range(0, 1));
      poke();
      @(posedge clk); #1;
    end
    bus.stall = 1'b0;
    bus.skip  = sk;
    poke();
    @(posedge clk); #1;
    bus.stall   = 1'b1;
    bus.skip    = 1'b0;
    bus.run     = 1'b0;
    bus.prog_we = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pc"}, 32'(bus.pc), 32'd0);
    chk({tag, "_inst"}, 32'(bus.inst_reg), 32'h00);
    chk({tag, "_valid"}, 32'(bus.inst_valid), 32'd0);
    chk({tag, "_halted"}, 32'(bus.halted), 32'd0);
    chk({tag, "_state"}, 32'(bus.state), 32'd0);
  endtask

  task automatic recover();
    reset = 1'b0;
    #1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_episode(input int n);
    int p = follow(0);
    int k = 0;
    bit hexp = 1'b0;
    int hpc = 0;
    bit ok;
    int g;
    while (k <= n) begin
      if (m[p] == 8'hFF) begin
        hexp = 1'b1;
        hpc  = p;
        break;
      end
      if (k == n) break;
      exp_q.push_back({6'(p), m[p]});
      p = follow((p + 1 + int'(skip_v[k])) % 64);
      k++;
    end
    start_run(m[0][7:6] != 2'b11);
    for (int i = 0; i < k; i++) begin
      deliver(stall_v[i], skip_v[i], ok);
      if (!ok) begin
        recover();
        return;
      end
    end
    if (hexp) begin
      g = 0;
      while (!bus.halted && g < 10) begin
        @(posedge clk); #1;
        g++;
      end
      chk("halted", 32'(bus.halted), 32'd1);
      chk("halt_pc", 32'(bus.pc), 32'(hpc));
      chk("halt_no_valid", 32'(bus.inst_valid), 32'd0);
      chk("halt_inst", 32'(bus.inst_reg), 32'hFF);
      chk("halt_queue_drained", 32'(exp_q.size()), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("halt_holds", 32'(bus.halted), 32'd1);
      chk("halt_pc_holds", 32'(bus.pc), 32'(hpc));
    end else begin
      g = 0;
      while (!bus.inst_valid && g < 8) begin
        @(posedge clk); #1;
        g++;
      end
      chk("abort_target_valid", 32'(bus.inst_valid), 32'd1);
      chk("abort_queue_drained", 32'(exp_q.size()), 32'd0);
      #2;
      reset = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      exp_q.delete();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_after_reset", 32'(bus.state), 32'd0);
    end
  endtask

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (reset && bus.inst_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got pc=%0d inst=%0h expected none", bus.pc, bus.inst_reg);
        end else begin
          chk("deliver_pc_inst", 32'({bus.pc, bus.inst_reg}), 32'(exp_q[0]));
          if (!bus.stall) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset         = 1'b1;
    bus.prog_we   = 1'b0;
    bus.prog_addr = 6'd0;
    bus.prog_data = 8'd0;
    bus.run       = 1'b0;
    bus.stall     = 1'b1;
    bus.skip      = 1'b0;
    #1 reset = 1'b0;
    #1;
    check_reset_outputs("reset");
    #20;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_wait_state", 32'(bus.state), 32'd0);
    chk("idle_wait_valid", 32'(bus.inst_valid), 32'd0);

    gen_program();
    load_all();

    // sequential run with a 3-cycle stall and locked-out writes to addr 1
    clear_ctl();
    write_word(0, 8'h1D);
    write_word(1, 8'h1F);
    write_word(2, 8'hFF);
    stall_v[0]  = 3;
    force_poke1 = 1'b1;
    run_episode(10);
    force_poke1 = 1'b0;

    // write in HALT, rerun fetches new word
    clear_ctl();
    write_word(1, 8'h2A);
    run_episode(10);

    // GOTO into the top of memory, 62+2 and 63+1 wrap
    clear_ctl();
    write_word(0, 8'h05);
    write_word(1, 8'hFD);
    write_word(61, 8'h21);
    write_word(62, 8'h22);
    write_word(63, 8'h23);
    skip_v[2] = 1'b1;
    skip_v[4] = 1'b1;
    run_episode(7);

    // skip at pc=1, GOTO 0 at pc=4
    clear_ctl();
    write_word(0, 8'h05);
    write_word(1, 8'h11);
    write_word(2, 8'h12);
    write_word(3, 8'h13);
    write_word(4, 8'hC0);
    skip_v[1] = 1'b1;
    run_episode(7);

    // randomized programs; every fourth reruns surviving memory
    for (int ep = 0; ep < 20; ep++) begin
      if (ep % 4 != 3) begin
        gen_program();
        load_all();
      end
      n = $urandom_range(1, 12);
      for (int i = 0; i < 32; i++) begin
        stall_v[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        skip_v[i]  = 1'($urandom_range(0, 1));
      end
      run_episode(n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port clk, input, 1, rising-edge clock for all state.
REQ-003 Port reset, input, 1, asynchronous active-low reset: 0 resets immediately; release is synchronous to clk.
REQ-004 Port prog_we, input, 1, program-memory write strobe.
REQ-005 Port prog_addr, input, 6, program-memory write address.
REQ-006 Port prog_data, input, 8, program-memory write data.
REQ-007 Port run, input, 1, start request; level sampled on clk.
REQ-008 Port stall, input, 1, consumer not ready; holds the current instruction.
REQ-009 Port skip, input, 1, execution-unit request to skip the next instruction.
REQ-010 Port inst_reg, output, 8, instruction word presented to the decoder.
REQ-011 Port inst_valid, output, 1, inst_reg holds a deliverable instruction this cycle.
REQ-012 Port pc, output, 6, address of the instruction in inst_reg, or of the next fetch.
REQ-013 Port halted, output, 1, sequencer stopped on HALT.

Function
REQ-014 Internal program memory SHALL be 64 x 8, written synchronously when prog_we=1 and the FSM is in IDLE or HALT; prog_we in any other state SHALL be ignored.
REQ-015 FSM states SHALL be IDLE, FETCH, EXEC and HALT.
REQ-016 IDLE: when run=1, clear pc to 0 and go to FETCH; otherwise stay in IDLE.
REQ-017 FETCH (1 cycle): load inst_reg <= mem[pc], then go to EXEC; inst_valid=0 during FETCH.
REQ-018 Latency: the first instruction SHALL appear with inst_valid=1 two cycles after the edge that sampled run=1.
REQ-019 EXEC, ordinary instruction: assert inst_valid=1.
  - If stall=1: hold EXEC with inst_reg, pc and inst_valid unchanged.
  - If stall=0: pc <= pc+1, or pc+2 if skip=1; then go to FETCH.
REQ-020 GOTO encoding: inst_reg[7:6]=2'b11 and inst_reg != 8'hFF.
  - In EXEC: pc <= inst_reg[5:0]; inst_valid=0; stall and skip ignored; next state FETCH.
REQ-021 HALT encoding: inst_reg = 8'hFF.
  - In EXEC: inst_valid=0; pc unchanged; go to HALT.
REQ-022 HALT state: halted=1. run=1 clears halted, sets pc to 0 and goes to FETCH.
REQ-023 PC arithmetic SHALL be modulo 64: 63+1 = 0, 63+2 = 1, 62+2 = 0.
REQ-024 skip and stall are sampled only in EXEC of an ordinary instruction; skip SHALL apply on the same cycle stall drops to 0, even if skip was asserted during the stall.
REQ-025 run in FETCH or EXEC SHALL be ignored.
REQ-026 inst_reg SHALL change only on a FETCH cycle or on reset.

Reset
REQ-027 While reset=0, independent of clk:
  - state = IDLE
  - pc = 0
  - inst_reg = 8'h00 (NOP)
  - inst_valid = 0
  - halted = 0
REQ-028 Program memory SHALL NOT be cleared by reset; its contents survive reset.
REQ-029 Reset asserted mid-FETCH or mid-EXEC SHALL abort the instruction with no pc update.
REQ-030 After reset release the FSM SHALL wait in IDLE for run.

Verification
REQ-031 Sequential run: load mem[0..2] = 8'h1D, 8'h1F, 8'hFF; pulse run.
  - Expect inst_valid with inst_reg=1D at pc=0, then 1F at pc=1.
  - Then halted=1 with pc=2 and no valid on FF.
REQ-032 Stall: with stall=1 for 3 cycles on pc=0, inst_reg=1D and inst_valid=1 SHALL stay stable for 4 cycles.
  - Next valid SHALL be pc=1.
REQ-033 Skip: skip=1 during EXEC at pc=1.
  - Next valid SHALL be pc=3.
  - With skip=1 at pc=62 and mem[0]=8'h05, next valid SHALL be pc=0, inst_reg=05.
REQ-034 GOTO: mem[4]=8'hC0.
  - After pc=3, no inst_valid for C0.
  - Next valid SHALL be pc=0.
  - Loop: PC 63 with a non-jump instruction SHALL wrap to pc=0.
REQ-035 Async reset: drive reset=0 between clock edges during EXEC at pc=5.
  - Outputs SHALL go to 0/00 immediately.
  - Memory SHALL be intact: a rerun fetches the same words.
REQ-036 Write lockout: prog_we during EXEC to addr 1 SHALL leave mem[1] unchanged.
  - Write in HALT then run SHALL fetch the new value.
